// File: rtl/peg_scorer.sv
// Mastermind peg scorer: latches code/guess on start and scores exact then colour-only matches over 8 cycles.
// Optional PEG_SORT_EN: rewrite the feedback pegs in sorted order (2s, then 1s, then 0s) when results are published.
module peg_scorer #(
  parameter int COLOR_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               last_turn,
  input  logic [COLOR_W-1:0] code0,
  input  logic [COLOR_W-1:0] code1,
  input  logic [COLOR_W-1:0] code2,
  input  logic [COLOR_W-1:0] code3,
  input  logic [COLOR_W-1:0] guess0,
  input  logic [COLOR_W-1:0] guess1,
  input  logic [COLOR_W-1:0] guess2,
  input  logic [COLOR_W-1:0] guess3,
  output logic               busy,
  output logic               done,
  output logic [1:0]         peg0,
  output logic [1:0]         peg1,
  output logic [1:0]         peg2,
  output logic [1:0]         peg3,
  output logic [2:0]         exact_cnt,
  output logic [2:0]         partial_cnt,
  output logic               win,
  output logic               lose,
  output logic               game_over
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] EXACT   = 2'd1;
  localparam logic [1:0] PARTIAL = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]         state_r;
  logic [1:0]         idx_r;
  logic [COLOR_W-1:0] code_r  [4];
  logic [COLOR_W-1:0] guess_r [4];
  logic [3:0]         used_r;
  logic [3:0]         hit_r;
  logic               last_r;
  logic [1:0]         peg_r   [4];
  logic [2:0]         exact_r;
  logic [2:0]         partial_r;
  logic               busy_r;
  logic               done_r;
  logic               win_r;
  logic               lose_r;

  logic               exact_match_s;
  logic               found_s;
  logic [1:0]         found_j_s;
  logic               partial_hit_s;
  logic [2:0]         partial_next_s;

`ifdef PEG_SORT_EN
  function automatic logic [1:0] sorted_peg(input logic [2:0] pos, input logic [2:0] ex,
                                            input logic [2:0] pa);
    if (pos < ex) begin
      sorted_peg = 2'd2;
    end else if (pos < ex + pa) begin
      sorted_peg = 2'd1;
    end else begin
      sorted_peg = 2'd0;
    end
  endfunction
`endif

  // Match search for the peg under the index; descending scan so the lowest free code slot wins.
  always_comb begin
    exact_match_s = (guess_r[idx_r] == code_r[idx_r]);
    found_s       = 1'b0;
    found_j_s     = 2'd0;
    for (int j = 3; j >= 0; j--) begin
      if (!used_r[j] && (code_r[j] == guess_r[idx_r])) begin
        found_s   = 1'b1;
        found_j_s = 2'(j);
      end else begin
        found_s   = found_s;
      end
    end
    partial_hit_s  = found_s && !hit_r[idx_r];
    partial_next_s = partial_r + {2'b00, partial_hit_s};
  end

  // Scoring sequencer and all registered results.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      idx_r     <= 2'd0;
      used_r    <= 4'd0;
      hit_r     <= 4'd0;
      last_r    <= 1'b0;
      exact_r   <= 3'd0;
      partial_r <= 3'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      win_r     <= 1'b0;
      lose_r    <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        code_r[i]  <= '0;
        guess_r[i] <= '0;
        peg_r[i]   <= 2'd0;
      end
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start && !(win_r || lose_r)) begin
            code_r[0]  <= code0;  code_r[1]  <= code1;
            code_r[2]  <= code2;  code_r[3]  <= code3;
            guess_r[0] <= guess0; guess_r[1] <= guess1;
            guess_r[2] <= guess2; guess_r[3] <= guess3;
            last_r     <= last_turn;
            used_r     <= 4'd0;
            hit_r      <= 4'd0;
            exact_r    <= 3'd0;
            partial_r  <= 3'd0;
            for (int i = 0; i < 4; i++) peg_r[i] <= 2'd0;
            idx_r      <= 2'd0;
            busy_r     <= 1'b1;
            state_r    <= EXACT;
          end
        end
        EXACT: begin
          if (exact_match_s) begin
            peg_r[idx_r]  <= 2'd2;
            used_r[idx_r] <= 1'b1;
            hit_r[idx_r]  <= 1'b1;
            exact_r       <= exact_r + 3'd1;
          end
          idx_r <= idx_r + 2'd1;
          if (idx_r == 2'd3) state_r <= PARTIAL;
        end
        PARTIAL: begin
          if (partial_hit_s) begin
            peg_r[idx_r]      <= 2'd1;
            used_r[found_j_s] <= 1'b1;
            partial_r         <= partial_next_s;
          end
          idx_r <= idx_r + 2'd1;
          // Results (including win/lose) are published together with the done pulse.
          if (idx_r == 2'd3) begin
            state_r <= DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            if (exact_r == 3'd4) win_r <= 1'b1;
            if (last_r && (exact_r != 3'd4)) lose_r <= 1'b1;
`ifdef PEG_SORT_EN
            for (int i = 0; i < 4; i++) peg_r[i] <= sorted_peg(3'(i), exact_r, partial_next_s);
`endif
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign peg0        = peg_r[0];
  assign peg1        = peg_r[1];
  assign peg2        = peg_r[2];
  assign peg3        = peg_r[3];
  assign exact_cnt   = exact_r;
  assign partial_cnt = partial_r;
  assign win         = win_r;
  assign lose        = lose_r;
  assign game_over   = win_r | lose_r;

endmodule
